// File: rtl/wbq_pkg.sv
// Shared types for the write-back queue: queue entry layout, register-file constants.
// Latency: n/a (types only); backpressure: n/a.
package wbq_pkg;

    localparam int         REG_COUNT = 16;
    localparam logic [3:0] REG_ZERO  = 4'd0;

    typedef struct packed {
        logic [3:0]  dest;
        logic [31:0] data;
    } wb_entry_t;

    // r0 is hardwired, so it never contributes to the pending mask.
    function automatic logic [REG_COUNT-1:0] dest_onehot(input logic [3:0] d);
        logic [REG_COUNT-1:0] m;
        m = '0;
        if (d != REG_ZERO) m[d] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_write_queue_if.sv
// Bundle of result inputs, register-file write port and ID hazard/forward signals.
// Forward ports exist only when WBQ_FWD_EN is defined.
interface wb_write_queue_if;

    logic        alu_valid;
    logic [3:0]  alu_dest;
    logic [31:0] alu_result;
    logic        mem_valid;
    logic [3:0]  mem_dest;
    logic [31:0] mem_rdata;
    logic        in_ready;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_result;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        hazard1;
    logic        hazard2;

`ifdef WBQ_FWD_EN
    logic        fwd1_valid;
    logic        fwd2_valid;
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;

    modport slave (
        input  alu_valid, alu_dest, alu_result, mem_valid, mem_dest, mem_rdata, src1, src2,
        output in_ready, wb_en, wb_dest, wb_result, hazard1, hazard2,
        output fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
    );
    modport master (
        output alu_valid, alu_dest, alu_result, mem_valid, mem_dest, mem_rdata, src1, src2,
        input  in_ready, wb_en, wb_dest, wb_result, hazard1, hazard2,
        input  fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
    );
`else
    modport slave (
        input  alu_valid, alu_dest, alu_result, mem_valid, mem_dest, mem_rdata, src1, src2,
        output in_ready, wb_en, wb_dest, wb_result, hazard1, hazard2
    );
    modport master (
        output alu_valid, alu_dest, alu_result, mem_valid, mem_dest, mem_rdata, src1, src2,
        input  in_ready, wb_en, wb_dest, wb_result, hazard1, hazard2
    );
`endif

endinterface

// File: rtl/wbq_youngest_match.sv
// Finds the youngest valid queue entry whose dest equals src (built only with WBQ_FWD_EN).
// Purely combinational; no backpressure.
`ifdef WBQ_FWD_EN
module wbq_youngest_match
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t [DEPTH-1:0]         entries,
    input  logic [DEPTH-1:0]              entry_vld,
    input  logic [$clog2(DEPTH)-1:0]      head,
    input  logic [3:0]                    src,
    output logic                          match,
    output logic [31:0]                   data
);

    localparam int PW = $clog2(DEPTH);

    // Walk oldest to youngest so the last hit left standing is the youngest.
    always_comb begin
        match = 1'b0;
        data  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (entry_vld[head + PW'(k)] && (entries[head + PW'(k)].dest == src) &&
                (src != REG_ZERO)) begin
                match = 1'b1;
                data  = entries[head + PW'(k)].data;
            end
        end
    end

endmodule
`endif

// File: rtl/wb_write_queue.sv
// Orders ALU and load results into one register-file write per cycle (1-cycle latency when empty),
// throttling both sources via in_ready; exports pending-dest hazards (+ forwarding under WBQ_FWD_EN).
module wb_write_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    wb_write_queue_if.slave bus
);

    localparam int             PW        = $clog2(DEPTH);
    localparam int             CW        = PW + 1;
    localparam logic [CW-1:0]  READY_MAX = CW'(DEPTH - 2);

    wb_entry_t [DEPTH-1:0]  entries;
    logic [DEPTH-1:0]       entry_vld;
    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [PW-1:0]          alu_slot;
    logic [CW-1:0]          count;
    logic                   mem_acc;
    logic                   alu_acc;
    logic                   pop;
    logic                   wb_en_q;
    logic [3:0]             wb_dest_q;
    logic [31:0]            wb_result_q;
    logic [REG_COUNT-1:0]   pend_mask;

    // Two free slots are guaranteed whenever in_ready is high, so both sources can land together.
    assign bus.in_ready = (count <= READY_MAX);
    assign mem_acc      = bus.mem_valid && bus.in_ready && (bus.mem_dest != REG_ZERO);
    assign alu_acc      = bus.alu_valid && bus.in_ready && (bus.alu_dest != REG_ZERO);
    assign pop          = (count != '0);
    assign alu_slot     = mem_acc ? (tail + PW'(1)) : tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            wb_en_q     <= 1'b0;
            wb_dest_q   <= REG_ZERO;
            wb_result_q <= '0;
        end else begin
            tail  <= tail + PW'(mem_acc) + PW'(alu_acc);
            count <= count + CW'(mem_acc) + CW'(alu_acc) - CW'(pop);
            if (pop) begin
                head        <= head + PW'(1);
                wb_en_q     <= 1'b1;
                wb_dest_q   <= entries[head].dest;
                wb_result_q <= entries[head].data;
            end else begin
                wb_en_q     <= 1'b0;
            end
        end
    end

    // Load data is older in program order than a same-cycle ALU result.
    always_ff @(posedge clk) begin
        if (mem_acc) entries[tail]     <= '{dest: bus.mem_dest, data: bus.mem_rdata};
        if (alu_acc) entries[alu_slot] <= '{dest: bus.alu_dest, data: bus.alu_result};
    end

    always_comb begin
        entry_vld = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count) entry_vld[head + PW'(k)] = 1'b1;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i]) pend_mask = pend_mask | dest_onehot(entries[i].dest);
        end
        if (wb_en_q) pend_mask = pend_mask | dest_onehot(wb_dest_q);
    end

    assign bus.wb_en     = wb_en_q;
    assign bus.wb_dest   = wb_dest_q;
    assign bus.wb_result = wb_result_q;
    assign bus.hazard1   = pend_mask[bus.src1];
    assign bus.hazard2   = pend_mask[bus.src2];

`ifdef WBQ_FWD_EN
    logic        q_match1;
    logic        q_match2;
    logic [31:0] q_data1;
    logic [31:0] q_data2;

    wbq_youngest_match #(.DEPTH(DEPTH)) u_match1 (
        .entries   (entries),
        .entry_vld (entry_vld),
        .head      (head),
        .src       (bus.src1),
        .match     (q_match1),
        .data      (q_data1)
    );

    wbq_youngest_match #(.DEPTH(DEPTH)) u_match2 (
        .entries   (entries),
        .entry_vld (entry_vld),
        .head      (head),
        .src       (bus.src2),
        .match     (q_match2),
        .data      (q_data2)
    );

    // Queued entries are younger than the one sitting in the write register.
    assign bus.fwd1_valid = pend_mask[bus.src1];
    assign bus.fwd2_valid = pend_mask[bus.src2];
    assign bus.fwd1_data  = q_match1 ? q_data1 : wb_result_q;
    assign bus.fwd2_data  = q_match2 ? q_data2 : wb_result_q;
`endif

    a_no_offer_when_full: assert property (
        @(posedge clk) disable iff (rst) (bus.alu_valid || bus.mem_valid) |-> bus.in_ready
    );

endmodule

// File: doc/wb_write_queue.md
# wb_write_queue

Write-back queue feeding the 16x32 register file's write port. Collects results from the EX/ALU path and the multi-cycle memory load path and orders them. Retires at most one register-file write per cycle. Exposes a pending-destination scoreboard so the ID stage can detect read-after-write hazards on its two source registers.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock; the register file samples writes on its negedge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result offered this cycle.
- alu_dest  in  4  ALU destination register.
- alu_result  in  32  ALU result.
- mem_valid  in  1  load data offered this cycle.
- mem_dest  in  4  load destination register.
- mem_rdata  in  32  load data.
- in_ready  out  1  both sources may present; common to both.
- wb_en  out  1  register-file write enable.
- wb_dest  out  4  register-file write address.
- wb_result  out  32  register-file write data.
- src1, src2  in  4  ID-stage source register numbers.
- hazard1, hazard2  out  1  a write to src1/src2 is still outstanding.
- fwd1_valid, fwd2_valid  out  1  present only with WBQ_FWD_EN.
- fwd1_data, fwd2_data  out  32  present only with WBQ_FWD_EN.

## Operation
- Queue: circular FIFO of {dest[3:0], data[31:0]}, with head and tail pointers and a count (0..DEPTH).
- Accept: a source is accepted when its valid is high and in_ready is high. A valid offered while in_ready is low is a protocol error, is ignored, and is flagged by an assertion.
- Both sources in the same cycle: the mem entry is enqueued first because it is older in program order; the ALU entry goes one slot behind it.
- dest == 0: the beat is accepted and discarded. It is never enqueued and never raises a hazard.
- in_ready = (count <= DEPTH-2). It is combinational from count only, so two entries always fit.
- Retire: each cycle with count > 0, the head is popped into the wb_* output registers with wb_en = 1. When count == 0, wb_en goes to 0 and wb_dest/wb_result hold their previous values.
- Pending mask (16 bits): the OR of one-hot(dest) over all valid queue entries and the current wb_* output register when wb_en = 1. hazard1 = mask[src1], hazard2 = mask[src2]. src == 0 never hazards.
- Duplicate destinations are allowed. Retire order guarantees the youngest value is the last one written.

## Timing
- Reset values: count = 0, pointers = 0, wb_en = 0, wb_dest = 0, wb_result = 0, in_ready = 1, hazards = 0, fwd valids = 0.
- Latency: an entry accepted at edge N into an empty queue appears with wb_en = 1 in cycle N+1 and is written to the register file at that cycle's negedge.
- Throughput: one retire per cycle. A sustained dual-source input stream drains in a 2:1 ratio, and in_ready throttles it.
- count update: count_next = count + accepted - popped. Accept and pop in the same cycle is allowed, including at count == DEPTH-2.
- Pointers wrap modulo DEPTH.
- Hazards are combinational from current state. A register clears in the cycle after its last write is on wb_*.
- Reset mid-operation flushes all entries. No write is issued after reset asserts.

## Configuration
- WBQ_FWD_EN defined:
  - fwdN_valid = mask[srcN].
  - fwdN_data = the value of the youngest entry (tail side first, then the wb_* register) whose dest == srcN.
  - This lets ID forward instead of stalling.
- WBQ_FWD_EN undefined: the fwd ports and the youngest-match search are not built, and ID must stall on hazardN.

## Structure
- Shared package wbq_pkg: wb_entry_t struct {logic [3:0] dest; logic [31:0] data;}, REG_COUNT = 16, REG_ZERO = 4'd0.
- One natural sub-module, wbq_youngest_match: takes the entry array, the valid bits, the head/count and one source index, and returns the match and data. It is instantiated twice and only under WBQ_FWD_EN.

## Test plan
- Reset, then alu_valid with dest=3, data=0xDEADBEEF at edge 1 -> wb_en=1, wb_dest=3, wb_result=0xDEADBEEF in cycle 2; hazard on src1=3 is high in cycles 1-2 and low in cycle 3.
- mem(dest=5, 0x11) and alu(dest=5, 0x22) in the same cycle -> writes 0x11 then 0x22 on consecutive cycles; with WBQ_FWD_EN, fwd1_data=0x22 for src1=5 before either retires.
- Dual-source stream, DEPTH=4 -> in_ready falls when count reaches 3; no entry is lost; retire order equals acceptance order across pointer wrap.
- alu_dest=0, data=0xFFFF -> no wb_en pulse, hazard1 low for src1=0, count stays 0.
- Fill to count=2, assert rst asynchronously mid-cycle -> wb_en=0 immediately; after release, no queued write appears and in_ready=1.
